rnn_step_sequencer: RTL and testbench

RNN_STEP_SEQUENCER -- requirements
Module: rnn_step_sequencer

---
 rtl/rnn_pkg.sv | 52 +++++
 rtl/rnn_mac.sv | 59 +++++
 rtl/rnn_step_sequencer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_rnn_step_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rnn_pkg.sv
// ---------------------------------------------------------------------------
// rnn_pkg
// Shared definitions for the RNN step sequencer:
//   - fixed-point data/accumulator widths and the default fraction width
//   - sequencer state enum and the operand-source tag used to line up
//     one-cycle-latency tensor reads with the accumulator
//   - signed 32 -> 16 bit saturation helpers
// ---------------------------------------------------------------------------
package rnn_pkg;

    localparam int DATA_W       = 16;
    localparam int ACC_W        = 32;
    localparam int FRAC_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MAC_X  = 3'd1,
        ST_MAC_H  = 3'd2,
        ST_BIAS   = 3'd3,
        ST_STORE  = 3'd4,
        ST_COMMIT = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Which operand pair was selected in the previous cycle (its read data
    // is on the *_rd buses in the current cycle).
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_X    = 2'd1,
        SRC_H    = 2'd2,
        SRC_B    = 2'd3
    } src_t;

    // True when v does not fit in signed 16 bits.
    function automatic logic is_sat16(input logic signed [ACC_W-1:0] v);
        return (v > 32'sh0000_7FFF) || (v < 32'shFFFF_8000);
    endfunction

    // Clamp a signed 32-bit value to signed 16 bits.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > 32'sh0000_7FFF) begin
            r = 16'h7FFF;
        end else if (v < 32'shFFFF_8000) begin
            r = 16'h8000;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rnn_mac.sv
// ---------------------------------------------------------------------------
// rnn_mac
// Signed 16x16 multiply, arithmetic right shift by FRAC, 32-bit accumulate.
// The accumulator wraps (no internal saturation).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            accumulator loads 0 at the next edge (overrides add)
//   mul_en         add (a*b)>>>FRAC this cycle
//   add_en         add sign-extended addend this cycle (used when !mul_en)
//   a, b, addend   16-bit signed operands
//   sum            accumulator plus this cycle's term (combinational)
// ---------------------------------------------------------------------------
module rnn_mac
    import rnn_pkg::*;
#(
    parameter int FRAC = FRAC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              mul_en,
    input  logic              add_en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] addend,
    output logic [ACC_W-1:0]  sum
);

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W-1:0] term_s;
    logic signed [ACC_W-1:0] sum_s;

    // Select this cycle's term and form the running sum.
    always_comb begin
        prod_s = ACC_W'($signed(a)) * ACC_W'($signed(b));
        if (mul_en) begin
            term_s = prod_s >>> FRAC;
        end else if (add_en) begin
            term_s = ACC_W'($signed(addend));
        end else begin
            term_s = 32'sd0;
        end
        sum_s = acc_r + term_s;
        sum   = sum_s;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 32'sd0;
        end else if (clr) begin
            acc_r <= 32'sd0;
        end else begin
            acc_r <= sum_s;
        end
    end

endmodule

// File: rtl/rnn_step_sequencer.sv
// ---------------------------------------------------------------------------
// rnn_step_sequencer
// Runs one RNN time step: for every hidden column j, accumulates
// x[k]*W0[k][j] over the input vector, h[k]*W1[k][j] over the old hidden
// vector, adds bias b[j], saturates to 16 bits and buffers the result.
// After all columns the buffer is committed to the hidden tensor, so the
// whole step only ever reads the old hidden state.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               step request (IDLE only) / synchronous cancel
//   busy, done                 not-IDLE flag / one-cycle completion pulse
//   i_sel, h_sel               input / hidden element selects
//   r0_sel_r, r0_sel_c         input-weight row / column select
//   r1_sel_r, r1_sel_c         recurrent-weight row / column select
//   rb_sel                     bias select
//   i_rd,h_rd,r0_rd,r1_rd,rb_rd  read data, one cycle after the select
//   h_write, h_wdata           hidden write strobe / data (at h_sel)
//   sat_flag                   sticky saturation flag for the current step
// Build option: define RNN_SEQ_RELU_EN to clamp negative stored results to 0.
// ---------------------------------------------------------------------------
module rnn_step_sequencer
    import rnn_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_HID = 16,
    parameter int FRAC  = FRAC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_IN)-1:0]  i_sel,
    output logic [$clog2(N_HID)-1:0] h_sel,
    output logic [$clog2(N_IN)-1:0]  r0_sel_r,
    output logic [$clog2(N_HID)-1:0] r0_sel_c,
    output logic [$clog2(N_HID)-1:0] r1_sel_r,
    output logic [$clog2(N_HID)-1:0] r1_sel_c,
    output logic [$clog2(N_HID)-1:0] rb_sel,
    input  logic [DATA_W-1:0]        i_rd,
    input  logic [DATA_W-1:0]        h_rd,
    input  logic [DATA_W-1:0]        r0_rd,
    input  logic [DATA_W-1:0]        r1_rd,
    input  logic [DATA_W-1:0]        rb_rd,
    output logic                     h_write,
    output logic [DATA_W-1:0]        h_wdata,
    output logic                     sat_flag
);

    localparam int IW = $clog2(N_IN);
    localparam int HW = $clog2(N_HID);
    localparam int KW = (IW > HW) ? IW : HW;

    localparam logic [KW-1:0] K_ONE    = KW'(1);
    localparam logic [KW-1:0] K_X_LAST = KW'(N_IN - 1);
    localparam logic [KW-1:0] K_H_LAST = KW'(N_HID - 1);
    localparam logic [HW-1:0] J_ONE    = HW'(1);
    localparam logic [HW-1:0] J_LAST   = HW'(N_HID - 1);

    state_t            state_r, state_s;
    logic [KW-1:0]     k_r, k_s;
    logic [HW-1:0]     j_r, j_s;
    src_t              src_r, src_s;

    logic [IW-1:0]     i_sel_s, r0_sel_r_s;
    logic [HW-1:0]     h_sel_s, r0_sel_c_s, r1_sel_r_s, r1_sel_c_s, rb_sel_s;
    logic              h_write_s;
    logic [DATA_W-1:0] h_wdata_s;

    logic              mul_en_s, add_en_s, clr_s;
    logic [DATA_W-1:0] mac_a_s, mac_b_s;
    logic [ACC_W-1:0]  sum_s;
    logic [DATA_W-1:0] store_val_s;
    logic              store_sat_s;

    logic [DATA_W-1:0] res_buf_r [N_HID];

    // Next-state and row/column counter logic; abort overrides everything.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        j_s     = j_r;
        if (abort) begin
            state_s = ST_IDLE;
            k_s     = {KW{1'b0}};
            j_s     = {HW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_MAC_X;
                        k_s     = {KW{1'b0}};
                        j_s     = {HW{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_MAC_X: begin
                    if (k_r == K_X_LAST) begin
                        state_s = ST_MAC_H;
                        k_s     = {KW{1'b0}};
                    end else begin
                        k_s = k_r + K_ONE;
                    end
                end
                ST_MAC_H: begin
                    if (k_r == K_H_LAST) begin
                        state_s = ST_BIAS;
                        k_s     = {KW{1'b0}};
                    end else begin
                        k_s = k_r + K_ONE;
                    end
                end
                ST_BIAS: state_s = ST_STORE;
                ST_STORE: begin
                    if (j_r == J_LAST) begin
                        state_s = ST_COMMIT;
                        j_s     = {HW{1'b0}};
                    end else begin
                        state_s = ST_MAC_X;
                        j_s     = j_r + J_ONE;
                    end
                    k_s = {KW{1'b0}};
                end
                ST_COMMIT: begin
                    if (k_r == K_H_LAST) begin
                        state_s = ST_DONE;
                        k_s     = {KW{1'b0}};
                    end else begin
                        k_s = k_r + K_ONE;
                    end
                end
                ST_DONE: state_s = ST_IDLE;
                default: begin
                    state_s = ST_IDLE;
                    k_s     = {KW{1'b0}};
                    j_s     = {HW{1'b0}};
                end
            endcase
        end
    end

    // Decode next-cycle outputs from the next state so they can be registered.
    always_comb begin
        i_sel_s    = {IW{1'b0}};
        r0_sel_r_s = {IW{1'b0}};
        r0_sel_c_s = {HW{1'b0}};
        h_sel_s    = {HW{1'b0}};
        r1_sel_r_s = {HW{1'b0}};
        r1_sel_c_s = {HW{1'b0}};
        rb_sel_s   = {HW{1'b0}};
        h_write_s  = 1'b0;
        h_wdata_s  = {DATA_W{1'b0}};
        case (state_s)
            ST_MAC_X: begin
                i_sel_s    = k_s[IW-1:0];
                r0_sel_r_s = k_s[IW-1:0];
                r0_sel_c_s = j_s;
            end
            ST_MAC_H: begin
                h_sel_s    = k_s[HW-1:0];
                r1_sel_r_s = k_s[HW-1:0];
                r1_sel_c_s = j_s;
            end
            ST_BIAS: rb_sel_s = j_s;
            ST_COMMIT: begin
                h_sel_s   = k_s[HW-1:0];
                h_write_s = 1'b1;
                h_wdata_s = res_buf_r[k_s[HW-1:0]];
            end
            default: ;
        endcase
    end

    // Operand source tag follows the state by one cycle to match read latency.
    always_comb begin
        if (abort) begin
            src_s = SRC_NONE;
        end else begin
            case (state_r)
                ST_MAC_X: src_s = SRC_X;
                ST_MAC_H: src_s = SRC_H;
                ST_BIAS:  src_s = SRC_B;
                default:  src_s = SRC_NONE;
            endcase
        end
    end

    // Route the previous cycle's read data into the MAC.
    always_comb begin
        mul_en_s = 1'b0;
        add_en_s = 1'b0;
        mac_a_s  = i_rd;
        mac_b_s  = r0_rd;
        case (src_r)
            SRC_X: mul_en_s = 1'b1;
            SRC_H: begin
                mul_en_s = 1'b1;
                mac_a_s  = h_rd;
                mac_b_s  = r1_rd;
            end
            SRC_B: add_en_s = 1'b1;
            default: ;
        endcase
        // STORE consumes the final sum (bias included) and restarts the column.
        clr_s = abort || (state_r == ST_IDLE) || (state_r == ST_STORE);
    end

    rnn_mac #(
        .FRAC (FRAC)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr_s),
        .mul_en (mul_en_s),
        .add_en (add_en_s),
        .a      (mac_a_s),
        .b      (mac_b_s),
        .addend (rb_rd),
        .sum    (sum_s)
    );

    // Saturate the column result (and optionally rectify it).
    always_comb begin
        store_val_s = sat16($signed(sum_s));
        store_sat_s = is_sat16($signed(sum_s));
`ifdef RNN_SEQ_RELU_EN
        if (store_val_s[DATA_W-1]) begin
            store_val_s = {DATA_W{1'b0}};
        end else begin
            store_val_s = store_val_s;
        end
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            k_r      <= {KW{1'b0}};
            j_r      <= {HW{1'b0}};
            src_r    <= SRC_NONE;
            busy     <= 1'b0;
            done     <= 1'b0;
            i_sel    <= {IW{1'b0}};
            r0_sel_r <= {IW{1'b0}};
            r0_sel_c <= {HW{1'b0}};
            h_sel    <= {HW{1'b0}};
            r1_sel_r <= {HW{1'b0}};
            r1_sel_c <= {HW{1'b0}};
            rb_sel   <= {HW{1'b0}};
            h_write  <= 1'b0;
            h_wdata  <= {DATA_W{1'b0}};
        end else begin
            state_r  <= state_s;
            k_r      <= k_s;
            j_r      <= j_s;
            src_r    <= src_s;
            busy     <= (state_s != ST_IDLE);
            done     <= (state_s == ST_DONE);
            i_sel    <= i_sel_s;
            r0_sel_r <= r0_sel_r_s;
            r0_sel_c <= r0_sel_c_s;
            h_sel    <= h_sel_s;
            r1_sel_r <= r1_sel_r_s;
            r1_sel_c <= r1_sel_c_s;
            rb_sel   <= rb_sel_s;
            h_write  <= h_write_s;
            h_wdata  <= h_wdata_s;
        end
    end

    // Sticky saturation flag, cleared when a step is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (!abort && (state_r == ST_IDLE) && start) begin
            sat_flag <= 1'b0;
        end else if (!abort && (state_r == ST_STORE) && store_sat_s) begin
            sat_flag <= 1'b1;
        end else begin
            sat_flag <= sat_flag;
        end
    end

    // Column result buffer; contents are only meaningful once COMMIT starts.
    always_ff @(posedge clk) begin
        if (!abort && (state_r == ST_STORE)) begin
            res_buf_r[j_r] <= store_val_s;
        end
    end

endmodule

// File: tb/tb_rnn_step_sequencer.sv
module tb_rnn_step_sequencer;

    localparam int N_IN     = 4;
    localparam int N_HID    = 16;
    localparam int FRAC     = 8;
    localparam int LAT      = N_HID * (N_IN + N_HID + 2) + N_HID + 1;
    localparam int FIRST_WR = N_HID * (N_IN + N_HID + 2) + 1;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic        busy, done, h_write, sat_flag;
    logic [1:0]  i_sel, r0_sel_r;
    logic [3:0]  h_sel, r0_sel_c, r1_sel_r, r1_sel_c, rb_sel;
    logic [15:0] i_rd, h_rd, r0_rd, r1_rd, rb_rd, h_wdata;

    logic [15:0] x_mem [N_IN];
    logic [15:0] w0    [N_IN][N_HID];
    logic [15:0] w1    [N_HID][N_HID];
    logic [15:0] b_mem [N_HID];
    logic [15:0] h_mem [N_HID];
    logic [15:0] h_init[N_HID];
    logic        h_load;

    logic [15:0] exp_h [N_HID];
    bit          exp_sat;

    int checks = 0;
    int errors = 0;

    rnn_step_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .i_sel(i_sel), .h_sel(h_sel),
        .r0_sel_r(r0_sel_r), .r0_sel_c(r0_sel_c),
        .r1_sel_r(r1_sel_r), .r1_sel_c(r1_sel_c), .rb_sel(rb_sel),
        .i_rd(i_rd), .h_rd(h_rd), .r0_rd(r0_rd), .r1_rd(r1_rd), .rb_rd(rb_rd),
        .h_write(h_write), .h_wdata(h_wdata), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Tensor memories: one-cycle read latency, hidden write on h_write.
    always @(posedge clk) begin
        i_rd  <= x_mem[i_sel];
        h_rd  <= h_mem[h_sel];
        r0_rd <= w0[r0_sel_r][r0_sel_c];
        r1_rd <= w1[r1_sel_r][r1_sel_c];
        rb_rd <= b_mem[rb_sel];
        if (h_load) h_mem <= h_init;
        else if (h_write) h_mem[h_sel] <= h_wdata;
    end

    function automatic logic [43:0] all_outs();
        return {busy, done, h_write, sat_flag, h_wdata, i_sel, h_sel,
                r0_sel_r, r0_sel_c, r1_sel_r, r1_sel_c, rb_sel};
    endfunction

    function automatic logic [15:0] small_rand();
        logic [15:0] r;
        r = 16'($urandom);
        return {{4{r[11]}}, r[11:0]};
    endfunction

    // Reference: new h[j] = sat(sum x*W0 >>> F + sum h_old*W1 >>> F + b).
    task automatic model_step();
        int acc;
        exp_sat = 1'b0;
        for (int j = 0; j < N_HID; j++) begin
            acc = 0;
            for (int k = 0; k < N_IN; k++)
                acc += (int'($signed(x_mem[k])) * int'($signed(w0[k][j]))) >>> FRAC;
            for (int k = 0; k < N_HID; k++)
                acc += (int'($signed(h_mem[k])) * int'($signed(w1[k][j]))) >>> FRAC;
            acc += int'($signed(b_mem[j]));
            if (acc > 32767) begin
                exp_h[j] = 16'h7FFF; exp_sat = 1'b1;
            end else if (acc < -32768) begin
                exp_h[j] = 16'h8000; exp_sat = 1'b1;
            end else begin
                exp_h[j] = 16'(acc);
            end
`ifdef RNN_SEQ_RELU_EN
            if (exp_h[j][15]) exp_h[j] = 16'h0000;
`endif
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < N_IN; k++) begin
            x_mem[k] = 16'h0000;
            for (int j = 0; j < N_HID; j++) w0[k][j] = 16'h0000;
        end
        for (int k = 0; k < N_HID; k++) begin
            b_mem[k] = 16'h0000;
            h_init[k] = 16'h0000;
            for (int j = 0; j < N_HID; j++) w1[k][j] = 16'h0000;
        end
    endtask

    task automatic load_hidden();
        @(posedge clk); #1 h_load = 1'b1;
        @(posedge clk); #1 h_load = 1'b0;
    endtask

    // Issue one start and observe a fixed window; optional mid-run pokes.
    task automatic run_step(input int start_poke, input int abort_poke,
                            output int done_lat, output int done_cnt,
                            output int n_wr, output int first_wr,
                            output logic busy_after);
        done_lat = -1; done_cnt = 0; n_wr = 0; first_wr = -1; busy_after = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= LAT + 8; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start = 1'b0;
            abort = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_lat < 0) done_lat = c;
            end
            if (h_write === 1'b1) begin
                n_wr++;
                if (first_wr < 0) first_wr = c;
            end
            if (c == abort_poke + 1) busy_after = busy;
            if (c == start_poke) start = 1'b1;
            if (c == abort_poke) abort = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; h_load = 1'b0;
        clear_all();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs() !== 44'd0) begin
            errors++; $display("FAIL reset_outs got=%h want=0", all_outs());
        end
        @(negedge clk) rst_n = 1'b1;
        load_hidden();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (all_outs() !== 44'd0) begin
                errors++; $display("FAIL idle_outs cyc=%0d got=%h want=0", c, all_outs());
            end
        end
    endtask

    task automatic test_directed_x();
        int dl, dc, nw, fw; logic ba;
        clear_all();
        x_mem[0] = 16'h0100;
        for (int j = 0; j < N_HID; j++) w0[0][j] = 16'h0200;
        load_hidden();
        run_step(-1, -1, dl, dc, nw, fw, ba);
        checks++;
        if (dl != LAT) begin errors++; $display("FAIL x_latency got=%0d want=%0d", dl, LAT); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL x_done_count got=%0d want=1", dc); end
        checks++;
        if (nw != N_HID) begin errors++; $display("FAIL x_writes got=%0d want=%0d", nw, N_HID); end
        checks++;
        if (fw != FIRST_WR) begin errors++; $display("FAIL x_first_write got=%0d want=%0d", fw, FIRST_WR); end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL x_sat got=%b want=0", sat_flag); end
        for (int j = 0; j < N_HID; j++) begin
            checks++;
            if (h_mem[j] !== 16'h0200) begin
                errors++; $display("FAIL x_h[%0d] got=%h want=0200", j, h_mem[j]);
            end
        end
    endtask

    task automatic test_identity();
        int dl, dc, nw, fw; logic ba;
        clear_all();
        for (int k = 0; k < N_HID; k++) begin
            w1[k][k] = 16'h0100;
            h_init[k] = 16'(k * 256);
            b_mem[k] = 16'h0080;
        end
        load_hidden();
        run_step(-1, -1, dl, dc, nw, fw, ba);
        checks++;
        if (dl != LAT) begin errors++; $display("FAIL id_latency got=%0d want=%0d", dl, LAT); end
        for (int j = 0; j < N_HID; j++) begin
            checks++;
            if (h_mem[j] !== 16'(j * 256 + 128)) begin
                errors++; $display("FAIL id_h[%0d] got=%h want=%h", j, h_mem[j], 16'(j * 256 + 128));
            end
        end
    endtask

    task automatic test_saturation();
        int dl, dc, nw, fw; logic ba;
        logic [15:0] neg_exp;
`ifdef RNN_SEQ_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'h8000;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            clear_all();
            for (int k = 0; k < N_IN; k++) begin
                x_mem[k] = 16'h7F00;
                for (int j = 0; j < N_HID; j++) w0[k][j] = (pass == 0) ? 16'h7F00 : 16'h8100;
            end
            load_hidden();
            run_step(-1, -1, dl, dc, nw, fw, ba);
            checks++;
            if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag pass=%0d got=%b want=1", pass, sat_flag); end
            for (int j = 0; j < N_HID; j++) begin
                checks++;
                if (h_mem[j] !== ((pass == 0) ? 16'h7FFF : neg_exp)) begin
                    errors++;
                    $display("FAIL sat_h pass=%0d j=%0d got=%h want=%h", pass, j, h_mem[j],
                             (pass == 0) ? 16'h7FFF : neg_exp);
                end
            end
        end
    endtask

    task automatic test_random();
        int dl, dc, nw, fw; logic ba;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < N_IN; k++) begin
                x_mem[k] = (it == 3) ? 16'($urandom) : small_rand();
                for (int j = 0; j < N_HID; j++) w0[k][j] = (it == 3) ? 16'($urandom) : small_rand();
            end
            for (int k = 0; k < N_HID; k++) begin
                b_mem[k] = small_rand();
                h_init[k] = small_rand();
                for (int j = 0; j < N_HID; j++) w1[k][j] = small_rand();
            end
            load_hidden();
            model_step();
            run_step(-1, -1, dl, dc, nw, fw, ba);
            checks++;
            if (dl != LAT || dc != 1 || nw != N_HID) begin
                errors++; $display("FAIL rnd_timing it=%0d lat=%0d done=%0d wr=%0d want %0d/1/%0d",
                                   it, dl, dc, nw, LAT, N_HID);
            end
            checks++;
            if (sat_flag !== exp_sat) begin
                errors++; $display("FAIL rnd_sat it=%0d got=%b want=%b", it, sat_flag, exp_sat);
            end
            for (int j = 0; j < N_HID; j++) begin
                checks++;
                if (h_mem[j] !== exp_h[j]) begin
                    errors++; $display("FAIL rnd_h it=%0d j=%0d got=%h want=%h", it, j, h_mem[j], exp_h[j]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int dl, dc, nw, fw; logic ba;
        for (int k = 0; k < N_HID; k++) h_init[k] = small_rand();
        load_hidden();
        // Column 3 MAC_H spans cycles 3*22+5 .. 3*22+20 after start.
        run_step(-1, 3 * (N_IN + N_HID + 2) + N_IN + 4, dl, dc, nw, fw, ba);
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", ba); end
        checks++;
        if (nw != 0 || dc != 0) begin errors++; $display("FAIL abort_activity wr=%0d done=%0d want 0/0", nw, dc); end
        for (int j = 0; j < N_HID; j++) begin
            checks++;
            if (h_mem[j] !== h_init[j]) begin
                errors++; $display("FAIL abort_h[%0d] got=%h want=%h", j, h_mem[j], h_init[j]);
            end
        end
        // abort wins over start in IDLE
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_vs_start busy got=%b want=0", busy); end
        // a normal step afterwards
        model_step();
        run_step(-1, -1, dl, dc, nw, fw, ba);
        checks++;
        if (dl != LAT) begin errors++; $display("FAIL post_abort_latency got=%0d want=%0d", dl, LAT); end
        for (int j = 0; j < N_HID; j++) begin
            checks++;
            if (h_mem[j] !== exp_h[j]) begin
                errors++; $display("FAIL post_abort_h[%0d] got=%h want=%h", j, h_mem[j], exp_h[j]);
            end
        end
    endtask

    task automatic test_start_in_commit();
        int dl, dc, nw, fw; logic ba;
        model_step();
        run_step(FIRST_WR + 5, -1, dl, dc, nw, fw, ba);
        checks++;
        if (dc != 1 || dl != LAT) begin
            errors++; $display("FAIL commit_start done_cnt=%0d lat=%0d want 1/%0d", dc, dl, LAT);
        end
        checks++;
        if (busy !== 1'b0 || nw != N_HID) begin
            errors++; $display("FAIL commit_start_after busy=%b wr=%0d want 0/%0d", busy, nw, N_HID);
        end
        for (int j = 0; j < N_HID; j++) begin
            checks++;
            if (h_mem[j] !== exp_h[j]) begin
                errors++; $display("FAIL commit_start_h[%0d] got=%h want=%h", j, h_mem[j], exp_h[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_x();
        test_identity();
        test_saturation();
        test_random();
        test_abort();
        test_start_in_commit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
